ram_loader: RTL and testbench
=============================

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter DEPTH, default 16, program RAM words (address width 4).
REQ-003 clk_i  input  1  clock; all logic on rising edge.
REQ-004 rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 byte_valid_i  input  1  upstream byte valid.
REQ-006 byte_data_i  input  8  upstream byte.
REQ-007 byte_ready_o  output  1  loader accepts byte; transfer = valid & ready.
REQ-008 clear_i  input  1  return from DONE/ERROR to HUNT, re-holding CPU.
REQ-009 ram_we_o  output  1  program RAM write strobe, one cycle per data byte.
REQ-010 ram_addr_o  output  4  program RAM write address.
REQ-011 ram_data_o  output  8  program RAM write data.
REQ-012 cpu_rstn_o  output  1  active-low hold of controller/datapath; high only in DONE.
REQ-013 busy_o  output  1  frame in progress (LEN, DATA or CSUM).
REQ-014 load_err_o  output  1  high while in ERROR.

Function
REQ-015 Frame = SYNC_BYTE, LEN, LEN data bytes, CSUM; CSUM = 8-bit sum mod 256 of data bytes.
REQ-016 FSM states HUNT, LEN, DATA, CSUM, DONE, ERROR; one state register, registered outputs.
REQ-017 byte_ready_o SHALL be 1 in HUNT, LEN, DATA, CSUM and 0 in DONE, ERROR.
REQ-018 HUNT: accepted byte == SYNC_BYTE -> LEN; any other byte discarded, stay HUNT.
REQ-019 LEN: accepted LEN in 1..DEPTH -> DATA, count loaded with LEN, address cleared, sum cleared; LEN 0 or > DEPTH -> ERROR.
REQ-020 DATA: each accepted byte SHALL produce ram_we_o=1 exactly the next cycle with ram_addr_o = current address and ram_data_o = byte; address +1, sum += byte, count -1.
REQ-021 DATA -> CSUM on acceptance of the last byte (count 1); no further writes in that frame.
REQ-022 Address SHALL never wrap; LEN bound guarantees max address DEPTH-1.
REQ-023 CSUM: accepted byte == sum -> DONE; mismatch -> ERROR; RAM contents already written are not undone.
REQ-024 DONE: cpu_rstn_o=1 on the cycle after entry; stays until clear_i or reset.
REQ-025 ERROR: cpu_rstn_o=0, load_err_o=1 until clear_i or reset.
REQ-026 clear_i in DONE or ERROR -> HUNT next cycle, cpu_rstn_o=0 same edge; clear_i ignored in other states.
REQ-027 Cycles without valid & ready SHALL not change state, count, sum or address; no timeout.
REQ-028 ram_we_o SHALL be 0 in all cycles not following a DATA acceptance.

Reset
REQ-029 rstn_i low SHALL force HUNT, ram_we_o=0, ram_addr_o=0, ram_data_o=0, cpu_rstn_o=0, busy_o=0, load_err_o=0, count=0, sum=0 immediately.
REQ-030 Reset mid-frame SHALL abandon the frame; next frame restarts at address 0 after SYNC_BYTE.

Structure
REQ-031 Shared package holds state encoding, SYNC_BYTE default, DEPTH and address width, alongside controller opcode constants.
REQ-032 Single module; no sub-module; RAM itself external.

Verification
REQ-033 Reset, send A5,03,11,22,33,66 back-to-back -> writes (0,11),(1,22),(2,33) one cycle after each accept; cpu_rstn_o=1 after CSUM.
REQ-034 Send 00,FF,A5,01,7E,7E -> 00/FF discarded in HUNT, single write (0,7E), DONE.
REQ-035 Send A5,02,01,02,04 -> writes (0,01),(1,02), ERROR, load_err_o=1, cpu_rstn_o=0, byte_ready_o=0; clear_i -> HUNT.
REQ-036 Send A5,00 and A5,11 (after clear) -> ERROR each time, no ram_we_o pulse.
REQ-037 Send A5,10 + 16 bytes 0x00..0x0F + 78 with random valid gaps -> 16 writes, addresses 0..15, DONE.
REQ-038 Assert rstn_i low after 2 data bytes of a 4-byte frame -> outputs to reset values immediately; new full frame loads from address 0.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared encodings and sizes for the boot loader and the controller it feeds.
package ram_loader_pkg;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int DEPTH_DEF = 16;
    localparam int ADDR_W = $clog2(DEPTH_DEF);
    typedef enum logic [2:0] {ST_HUNT, ST_LEN, ST_DATA, ST_CSUM, ST_DONE, ST_ERROR} state_e;
    // controller opcodes the loaded program is made of
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JZ  = 4'h5;
    localparam logic [3:0] OP_OUT = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;
    function automatic logic in_frame(state_e s);
        return s inside {ST_LEN, ST_DATA, ST_CSUM};
    endfunction
endpackage

// File: rtl/ram_loader.sv
// ram_loader: parses SYNC/LEN/DATA/CSUM byte frames into program RAM and holds the CPU
// in reset until a frame with a matching checksum has been loaded.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_data_i,
    output logic          byte_ready_o,
    input  logic          clear_i,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [7:0]    ram_data_o,
    output logic          cpu_rstn_o,
    output logic          busy_o,
    output logic          load_err_o
);
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);
    state_e state, nxt;
    logic [CW-1:0] count;
    logic [AW-1:0] addr;
    logic [7:0] sum;
    logic acc, len_ok, last;
    assign acc = byte_valid_i & byte_ready_o;
    assign len_ok = byte_data_i != 8'd0 && {1'b0, byte_data_i} <= DEPTH_W;
    assign last = count == CW'(1);
    always_comb begin
        nxt = state;
        case (state)
            ST_HUNT:           nxt = acc && byte_data_i == SYNC_BYTE ? ST_LEN : ST_HUNT;
            ST_LEN:            nxt = !acc ? ST_LEN : len_ok ? ST_DATA : ST_ERROR;
            ST_DATA:           nxt = acc && last ? ST_CSUM : ST_DATA;
            ST_CSUM:           nxt = !acc ? ST_CSUM : byte_data_i == sum ? ST_DONE : ST_ERROR;
            ST_DONE, ST_ERROR: nxt = clear_i ? ST_HUNT : state;
            default:           nxt = ST_HUNT;
        endcase
    end
    // outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= ST_HUNT;
            byte_ready_o <= 1'b1;
            ram_we_o     <= 1'b0;
            ram_addr_o   <= '0;
            ram_data_o   <= '0;
            cpu_rstn_o   <= 1'b0;
            busy_o       <= 1'b0;
            load_err_o   <= 1'b0;
            count        <= '0;
            addr         <= '0;
            sum          <= '0;
        end else begin
            state        <= nxt;
            byte_ready_o <= nxt inside {ST_HUNT, ST_LEN, ST_DATA, ST_CSUM};
            cpu_rstn_o   <= nxt == ST_DONE;
            busy_o       <= in_frame(nxt);
            load_err_o   <= nxt == ST_ERROR;
            ram_we_o     <= acc && state == ST_DATA;
            if (acc && state == ST_LEN && len_ok) begin
                count <= CW'(byte_data_i);
                addr  <= '0;
                sum   <= '0;
            end
            // the address stops on the last byte so it never wraps past DEPTH-1
            if (acc && state == ST_DATA) begin
                ram_addr_o <= addr;
                ram_data_o <= byte_data_i;
                sum        <= sum + byte_data_i;
                count      <= count - CW'(1);
                if (!last) addr <= addr + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: table-driven frames, randomized frames and reset corner cases,
// checked every cycle against a byte-stream frame parser model.
module tb_ram_loader;
    logic clk_i = 1'b0, rstn_i = 1'b1, byte_valid_i = 1'b0, clear_i = 1'b0;
    logic [7:0] byte_data_i = 8'h00;
    logic byte_ready_o, ram_we_o, cpu_rstn_o, busy_o, load_err_o;
    logic [3:0] ram_addr_o;
    logic [7:0] ram_data_o;
    int n_chk = 0, n_err = 0;
    bit chk_en = 1'b0;
    // model: phase 0 hunt, 1 len, 2 data, 3 csum, 4 done, 5 error
    int ph = 0, rem = 0, ad = 0;
    logic [7:0] sm = 8'h00;
    bit exp_we = 1'b0;
    logic [3:0] exp_a = 4'h0;
    logic [7:0] exp_d = 8'h00;
    int wr_n = 0;
    logic [3:0] wr_a [16];
    logic [7:0] wr_d [16];
    typedef struct {
        logic [0:7][7:0] b;
        int n;
        int nwr;
        logic [0:3][7:0] wr;
        bit done;
    } vec_t;
    vec_t tv [7];

    ram_loader dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
        .byte_ready_o(byte_ready_o), .clear_i(clear_i), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_data_o(ram_data_o), .cpu_rstn_o(cpu_rstn_o), .busy_o(busy_o), .load_err_o(load_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ph <= 0; rem <= 0; ad <= 0; sm <= 8'h00;
            exp_we <= 1'b0; exp_a <= 4'h0; exp_d <= 8'h00;
        end else begin
            exp_we <= 1'b0;
            if (ph >= 4) begin
                if (clear_i) ph <= 0;
            end else if (byte_valid_i) begin
                case (ph)
                    0: if (byte_data_i == 8'hA5) ph <= 1;
                    1: if (byte_data_i >= 8'd1 && byte_data_i <= 8'd16) begin
                           ph <= 2; rem <= int'(byte_data_i); ad <= 0; sm <= 8'h00;
                       end else ph <= 5;
                    2: begin
                           exp_we <= 1'b1; exp_a <= 4'(ad); exp_d <= byte_data_i;
                           ad <= ad + 1; sm <= sm + byte_data_i; rem <= rem - 1;
                           if (rem == 1) ph <= 3;
                       end
                    default: ph <= (byte_data_i == sm) ? 4 : 5;
                endcase
            end
        end
    end

    always @(negedge clk_i) begin
        if (rstn_i && ram_we_o) begin
            if (wr_n < 16) begin
                wr_a[wr_n] = ram_addr_o;
                wr_d[wr_n] = ram_data_o;
            end
            wr_n++;
        end
        if (chk_en && rstn_i) begin
            chk("we", ram_we_o, exp_we);
            if (exp_we) begin
                chk("addr", ram_addr_o, exp_a);
                chk("data", ram_data_o, exp_d);
            end
            chk("ready", byte_ready_o, ph < 4);
            chk("cpu_rstn", cpu_rstn_o, ph == 4);
            chk("load_err", load_err_o, ph == 5);
            chk("busy", busy_o, ph >= 1 && ph <= 3);
        end
    end

    task automatic send(input logic [7:0] b);
        bit ok = 1'b0;
        byte_valid_i = 1'b1;
        byte_data_i = b;
        for (int t = 0; t < 20 && !ok; t++) begin
            ok = byte_ready_o;
            @(negedge clk_i);
        end
        byte_valid_i = 1'b0;
        chk("accept", ok, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic chk_rst(input string nm);
        chk({nm, "_we"}, ram_we_o, 0);
        chk({nm, "_addr"}, ram_addr_o, 0);
        chk({nm, "_data"}, ram_data_o, 0);
        chk({nm, "_cpu"}, cpu_rstn_o, 0);
        chk({nm, "_busy"}, busy_o, 0);
        chk({nm, "_err"}, load_err_o, 0);
        chk({nm, "_ready"}, byte_ready_o, 1);
    endtask

    task automatic finish_frame(input string nm, input bit done, input int nwr);
        idle(2);
        chk({nm, "_done"}, cpu_rstn_o, done);
        chk({nm, "_err"}, load_err_o, !done);
        chk({nm, "_nwr"}, wr_n, nwr);
        for (int k = 0; k < nwr && k < 16; k++) chk({nm, "_wa"}, wr_a[k], k);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0].b = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66, 8'h00, 8'h00}; tv[0].n = 6; tv[0].nwr = 3;
        tv[0].wr = {8'h11, 8'h22, 8'h33, 8'h00}; tv[0].done = 1;
        tv[1].b = {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7E, 8'h00, 8'h00}; tv[1].n = 6; tv[1].nwr = 1;
        tv[1].wr = {8'h7E, 8'h00, 8'h00, 8'h00}; tv[1].done = 1;
        tv[2].b = {8'hA5, 8'h02, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00}; tv[2].n = 5; tv[2].nwr = 2;
        tv[2].wr = {8'h01, 8'h02, 8'h00, 8'h00}; tv[2].done = 0;
        tv[3].b = {8'hA5, 8'h00, 48'h0}; tv[3].n = 2; tv[3].nwr = 0; tv[3].wr = '0; tv[3].done = 0;
        tv[4].b = {8'hA5, 8'h11, 48'h0}; tv[4].n = 2; tv[4].nwr = 0; tv[4].wr = '0; tv[4].done = 0;
        tv[5].b = {8'hA5, 8'h02, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}; tv[5].n = 5; tv[5].nwr = 2;
        tv[5].wr = {8'hFF, 8'h01, 8'h00, 8'h00}; tv[5].done = 1;
        tv[6].b = {8'hA5, 8'hA5, 48'h0}; tv[6].n = 2; tv[6].nwr = 0; tv[6].wr = '0; tv[6].done = 0;

        #1 rstn_i = 1'b0;
        #1 chk_rst("reset");
        idle(3);
        rstn_i = 1'b1;
        chk_en = 1'b1;
        pulse_clear();

        for (int i = 0; i < 7; i++) begin
            wr_n = 0;
            for (int k = 0; k < tv[i].n; k++) send(tv[i].b[k]);
            finish_frame($sformatf("vec%0d", i), tv[i].done, tv[i].nwr);
            for (int k = 0; k < tv[i].nwr; k++) chk($sformatf("vec%0d_wd", i), wr_d[k], tv[i].wr[k]);
            pulse_clear();
        end

        wr_n = 0;
        send(8'hA5);
        send(8'h10);
        for (int k = 0; k < 16; k++) begin
            idle($urandom_range(0, 3));
            send(8'(k));
        end
        send(8'h78);
        finish_frame("full", 1, 16);
        for (int k = 0; k < 16; k++) chk("full_wd", wr_d[k], k);
        pulse_clear();

        for (int f = 0; f < 20; f++) begin
            int len;
            bit bad_len, good;
            logic [7:0] s, b;
            wr_n = 0;
            s = 8'h00;
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                send(b == 8'hA5 ? 8'h5A : b);
            end
            bad_len = $urandom_range(0, 9) == 0;
            len = bad_len ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255)) : $urandom_range(1, 16);
            good = $urandom_range(0, 4) != 0;
            send(8'hA5);
            send(8'(len));
            if (!bad_len) begin
                for (int k = 0; k < len; k++) begin
                    idle($urandom_range(0, 2));
                    b = 8'($urandom);
                    s = s + b;
                    send(b);
                end
                send(good ? s : s ^ 8'h01);
            end
            finish_frame("rnd", good && !bad_len, bad_len ? 0 : len);
            pulse_clear();
        end

        wr_n = 0;
        send(8'hA5);
        send(8'h04);
        send(8'h01);
        send(8'h02);
        #2 rstn_i = 1'b0;
        chk_en = 1'b0;
        #1 chk_rst("midreset");
        @(negedge clk_i);
        rstn_i = 1'b1;
        chk_en = 1'b1;
        wr_n = 0;
        send(8'hA5);
        send(8'h03);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        send(8'h31);
        finish_frame("after_reset", 1, 3);
        chk("after_reset_wd0", wr_d[0], 8'hAA);
        chk("after_reset_wd2", wr_d[2], 8'hCC);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
